// File: rtl/byte_deserializer_pkg.sv
// Shared definitions for the serial-to-parallel deserializer and its register stage.
package byte_deserializer_pkg;

  // Word width shared with the downstream 8-bit holding register.
  localparam int unsigned DES_WIDTH_DEFAULT = 8;

  // Framing state: hunting for a sync marker, or assembling a word.
  typedef enum logic {
    ST_HUNT  = 1'b0,
    ST_SHIFT = 1'b1
  } des_state_e;

endpackage : byte_deserializer_pkg

// File: rtl/byte_deserializer_bit_counter.sv
// Bit position counter: counts qualified bits 0..WIDTH-1 within a word.
module bit_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic clear,
  input  logic load1,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] TC_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  // Terminal count: the next enabled bit completes the word.
  assign tc_c = (count == TC_VAL);

  // Clear wins, then restart at 1 (sync bit already stored), then count with wrap.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (load1) begin
      count <= CW'(1);
    end else if (en) begin
      count <= tc_c ? '0 : count + CW'(1);
    end
  end

endmodule : bit_counter

// File: rtl/byte_deserializer.sv
// Serial-in, parallel-out deserializer with sync-marker framing and a
// valid/ready output register that flags words lost to back-pressure.
module byte_deserializer
  import byte_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DES_WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  des_state_e       state_q;
  des_state_e       state_d;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] start_word_c;
  logic [WIDTH-1:0] shift_word_c;
  logic             cnt_load1_c;
  logic             cnt_en_c;
  logic             tc_c;
  logic             word_done_c;

  // Bit ordering: where a new bit enters and where a sync bit starts.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_word_c = {shreg[WIDTH-2:0], sin};
      assign start_word_c = {{(WIDTH-1){1'b0}}, sin};
    end else begin : g_lsb_first
      assign shift_word_c = {sin, shreg[WIDTH-1:1]};
      assign start_word_c = {sin, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  // Position within the current word.
  bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .clear (reset),
    .load1 (cnt_load1_c),
    .en    (cnt_en_c),
    .tc_c  (tc_c)
  );

  // Framing state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-bit controls; a sync bit always restarts the word.
  always_comb begin
    state_d     = state_q;
    cnt_load1_c = 1'b0;
    cnt_en_c    = 1'b0;
    word_done_c = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (sin_valid && sync) begin
          state_d     = ST_SHIFT;
          cnt_load1_c = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sin_valid) begin
          if (sync) begin
            cnt_load1_c = 1'b1;
          end else begin
            cnt_en_c    = 1'b1;
            word_done_c = tc_c;
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  // Shift register: restart on sync, shift on every other qualified bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
    end else if (cnt_load1_c) begin
      shreg <= start_word_c;
    end else if (cnt_en_c) begin
      shreg <= shift_word_c;
    end
  end

  // Output register: load on completion when free or being drained, else flag overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (word_done_c) begin
      if (!out_valid || out_ready) begin
        out       <= shift_word_c;
        out_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : byte_deserializer

// File: tb/tb_byte_deserializer.sv
// Directed bench for byte_deserializer: MSB-first and LSB-first instances
// share stimulus and are checked every cycle against a queue-style model.
module tb_byte_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sync = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_m;
  logic [7:0] out_l;
  logic       ov_m;
  logic       ov_l;
  logic       orun_m;
  logic       orun_l;

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  byte_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .out(out_m), .out_valid(ov_m), .out_ready(out_ready), .overrun(orun_m)
  );

  byte_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .out(out_l), .out_valid(ov_l), .out_ready(out_ready), .overrun(orun_l)
  );

  // Model: bits collected since the last sync; a full list of 8 is a word.
  bit         m_hunt = 1'b1;
  int         m_n = 0;
  bit         m_buf [8];
  logic [7:0] e_m = '0;
  logic [7:0] e_l = '0;
  logic       e_v = 1'b0;
  logic       e_o = 1'b0;

  always @(posedge clk) begin : model
    bit         done;
    logic [7:0] wm;
    logic [7:0] wl;
    done = 1'b0;
    if (reset) begin
      m_hunt = 1'b1;
      m_n    = 0;
      e_m    = '0;
      e_l    = '0;
      e_v    = 1'b0;
      e_o    = 1'b0;
    end else begin
      if (sin_valid) begin
        if (sync) begin
          m_hunt   = 1'b0;
          m_buf[0] = sin;
          m_n      = 1;
        end else if (!m_hunt) begin
          m_buf[m_n] = sin;
          m_n        = m_n + 1;
          if (m_n == 8) begin
            done = 1'b1;
            m_n  = 0;
          end
        end
      end
      if (done) begin
        for (int i = 0; i < 8; i++) begin
          wm[7-i] = m_buf[i];
          wl[i]   = m_buf[i];
        end
        if (!e_v || out_ready) begin
          e_m = wm;
          e_l = wl;
          e_v = 1'b1;
        end else begin
          e_o = 1'b1;
        end
      end else if (e_v && out_ready) begin
        e_v = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model out msb", out_m, e_m);
      check("model out lsb", out_l, e_l);
      check("model valid msb", 8'(ov_m), 8'(e_v));
      check("model valid lsb", 8'(ov_l), 8'(e_v));
      check("model overrun msb", 8'(orun_m), 8'(e_o));
      check("model overrun lsb", 8'(orun_l), 8'(e_o));
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic v, input logic d, input logic s);
    sin_valid = v;
    sin       = d;
    sync      = s;
    @(posedge clk);
    #1;
  endtask

  // One qualified bit followed by idle cycles carrying junk on sin/sync.
  task automatic send_bit(input logic d, input logic s, input int gap);
    cyc(1'b1, d, s);
    repeat (gap) cyc(1'b0, 1'($urandom), 1'($urandom));
  endtask

  // Word sent first-bit = w[7]; gaps between bits, none after the last.
  task automatic send_word(input logic [7:0] w, input logic s);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], s && (i == 7), (i == 0) ? 0 : int'($urandom_range(1, 3)));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic check_lit(input string tag, input logic [7:0] em, input logic [7:0] el,
                           input logic v, input logic o);
    check({tag, " out msb"}, out_m, em);
    check({tag, " out lsb"}, out_l, el);
    check({tag, " valid"}, 8'(ov_m), 8'(v));
    check({tag, " overrun"}, 8'(orun_m), 8'(o));
  endtask

  initial begin
    logic [7:0] w;
    do_reset();
    cmp_en = 1'b1;
    check_lit("reset", 8'h00, 8'h00, 1'b0, 1'b0);

    // 1: basic word, ready high; valid one clock after bit 8.
    out_ready = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    send_word(8'hF0, 1'b1);
    check_lit("t1", 8'hF0, 8'h0F, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // 2: no sync in HUNT; everything ignored.
    do_reset();
    send_word(8'hAA, 1'b0);
    send_word(8'hAA, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    check_lit("t2", 8'h00, 8'h00, 1'b0, 1'b0);

    // 3: back-pressure; second word lost, overrun sticky.
    do_reset();
    out_ready = 1'b0;
    send_word(8'h3C, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0);
    check_lit("t3", 8'h3C, 8'h3C, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check_lit("t3 hold", 8'h3C, 8'h3C, 1'b1, 1'b1);

    // 4: ready arrives exactly as the second word completes.
    do_reset();
    out_ready = 1'b0;
    send_word(8'hA5, 1'b1);
    w = 8'h55;
    for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0, int'($urandom_range(1, 3)));
    out_ready = 1'b1;
    cyc(1'b1, w[0], 1'b0);
    out_ready = 1'b0;
    check_lit("t4", 8'h55, 8'hAA, 1'b1, 1'b0);
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check_lit("t4 drain", 8'h55, 8'hAA, 1'b0, 1'b0);

    // 5: re-sync after 5 bits discards the partial word.
    do_reset();
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1, 2);
    send_bit(1'b1, 1'b0, 1);
    send_bit(1'b0, 1'b0, 3);
    send_bit(1'b1, 1'b0, 1);
    send_bit(1'b1, 1'b0, 2);
    send_word(8'h81, 1'b1);
    check_lit("t5", 8'h81, 8'h81, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // 6a: reset after 4 bits; following bits ignored until a new sync.
    do_reset();
    send_bit(1'b1, 1'b1, 1);
    send_bit(1'b0, 1'b0, 2);
    send_bit(1'b1, 1'b0, 1);
    send_bit(1'b1, 1'b0, 0);
    do_reset();
    check_lit("t6a", 8'h00, 8'h00, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check_lit("t6a ignored", 8'h00, 8'h00, 1'b0, 1'b0);
    send_word(8'h42, 1'b1);
    check_lit("t6a resync", 8'h42, 8'h42, 1'b1, 1'b0);

    // 6b: reset while holding a word with overrun set.
    do_reset();
    out_ready = 1'b0;
    send_word(8'h3C, 1'b1);
    send_word(8'hC3, 1'b0);
    check_lit("t6b hold", 8'h3C, 8'h3C, 1'b1, 1'b1);
    do_reset();
    check_lit("t6b reset", 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_byte_deserializer
